// File: rtl/exec_wb_stage.sv
// exec_wb_stage
//   Execute-to-writeback pipeline stage. It is a two-entry elastic buffer
//   (main + skid) between the ALU and register-file writeback. It also
//   owns the architectural C/V/Z flags, the PC redirect for taken DJ jumps
//   and a forwarding tap on the oldest pending register write.
//
//   Entries leave in strict FIFO order. ex_ready is registered and never
//   looks at wb_ready in the same cycle.
//
// Ports
//   clk, reset        : clock (rising edge), asynchronous active-high reset
//   ex_valid/ex_ready : upstream handshake from the ALU stage
//   ex_dout           : ALU result
//   ex_cout/ex_vout   : ALU carry / overflow
//   ex_djtaken        : decrement-jump condition taken
//   ex_rdest/ex_wen   : destination register and its write enable
//   ex_flag_we        : instruction updates C/V/Z
//   ex_is_dj          : instruction is a DJ-class jump
//   ex_target         : jump target address
//   wb_valid/wb_ready : downstream handshake to writeback
//   wb_data/wb_rdest/wb_wen : writeback payload (from the main entry)
//   cflag/vflag/zflag : architectural flags
//   redirect_valid/redirect_pc : one-cycle PC redirect after a taken DJ jump
//   fwd_valid/fwd_rdest/fwd_data : forwarding of the oldest pending write
module exec_wb_stage #(
  parameter int DW = 32,
  parameter int AW = 24,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [DW-1:0] ex_dout,
  input  logic          ex_cout,
  input  logic          ex_vout,
  input  logic          ex_djtaken,
  input  logic [RW-1:0] ex_rdest,
  input  logic          ex_wen,
  input  logic          ex_flag_we,
  input  logic          ex_is_dj,
  input  logic [AW-1:0] ex_target,
  output logic          wb_valid,
  input  logic          wb_ready,
  output logic [DW-1:0] wb_data,
  output logic [RW-1:0] wb_rdest,
  output logic          wb_wen,
  output logic          cflag,
  output logic          vflag,
  output logic          zflag,
  output logic          redirect_valid,
  output logic [AW-1:0] redirect_pc,
  output logic          fwd_valid,
  output logic [RW-1:0] fwd_rdest,
  output logic [DW-1:0] fwd_data
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [RW-1:0] rdest;
    logic          wen;
  } entry_t;

  state_e        state_q, state_d;
  entry_t        m_q, m_d;
  entry_t        s_q, s_d;
  entry_t        new_s;
  logic          ex_ready_q, ex_ready_d;
  logic          cflag_q, cflag_d;
  logic          vflag_q, vflag_d;
  logic          zflag_q, zflag_d;
  logic          redir_q, redir_d;
  logic [AW-1:0] redir_pc_q, redir_pc_d;

  logic accept_s;
  logic store_s;
  logic pop_s;
  logic m_valid_s;

  assign m_valid_s = (state_q != ST_EMPTY);
  assign accept_s  = ex_valid & ex_ready_q;
  // Anything accepted in the redirect shadow is discarded outright.
  assign store_s   = accept_s & ~redir_q;
  assign pop_s     = m_valid_s & wb_ready;

  assign new_s.data  = ex_dout;
  assign new_s.rdest = ex_rdest;
  assign new_s.wen   = ex_wen;

  // Occupancy next-state and entry movement between main and skid slots.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    case (state_q)
      ST_EMPTY: begin
        if (store_s) begin
          m_d     = new_s;
          state_d = ST_ONE;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (store_s && pop_s) begin
          // Main drains and refills on the same edge: occupancy unchanged.
          m_d     = new_s;
          state_d = ST_ONE;
        end else if (store_s) begin
          s_d     = new_s;
          state_d = ST_FULL;
        end else if (pop_s) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_FULL: begin
        // ex_ready is low here, so no store can coincide with the pop.
        if (pop_s) begin
          m_d     = s_q;
          state_d = ST_ONE;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    ex_ready_d = (state_d != ST_FULL);
  end

  // Flag update and redirect generation, both qualified by a real store.
  always_comb begin
    cflag_d    = cflag_q;
    vflag_d    = vflag_q;
    zflag_d    = zflag_q;
    redir_pc_d = redir_pc_q;
    if (store_s && ex_flag_we) begin
      cflag_d = ex_cout;
      vflag_d = ex_vout;
      zflag_d = (ex_dout == {DW{1'b0}});
    end else begin
      cflag_d = cflag_q;
    end
    redir_d = store_s & ex_is_dj & ex_djtaken;
    if (redir_d) begin
      redir_pc_d = ex_target;
    end else begin
      redir_pc_d = redir_pc_q;
    end
  end

  // State, payload, flag and redirect registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      m_q        <= '{data: {DW{1'b0}}, rdest: {RW{1'b0}}, wen: 1'b0};
      s_q        <= '{data: {DW{1'b0}}, rdest: {RW{1'b0}}, wen: 1'b0};
      ex_ready_q <= 1'b0;
      cflag_q    <= 1'b0;
      vflag_q    <= 1'b0;
      zflag_q    <= 1'b0;
      redir_q    <= 1'b0;
      redir_pc_q <= {AW{1'b0}};
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      s_q        <= s_d;
      ex_ready_q <= ex_ready_d;
      cflag_q    <= cflag_d;
      vflag_q    <= vflag_d;
      zflag_q    <= zflag_d;
      redir_q    <= redir_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  assign ex_ready       = ex_ready_q;
  assign wb_valid       = m_valid_s;
  assign wb_data        = m_q.data;
  assign wb_rdest       = m_q.rdest;
  assign wb_wen         = m_q.wen;
  assign cflag          = cflag_q;
  assign vflag          = vflag_q;
  assign zflag          = zflag_q;
  assign redirect_valid = redir_q;
  assign redirect_pc    = redir_pc_q;
  assign fwd_valid      = m_valid_s & m_q.wen;
  assign fwd_rdest      = m_q.rdest;
  assign fwd_data       = m_q.data;

endmodule

// File: doc/exec_wb_stage.md
EXEC_WB_STAGE -- requirements
Module: exec_wb_stage

Interface
REQ-001 Parameter DW, 32, datapath width (ALU result width).
REQ-002 Parameter AW, 24, program address width.
REQ-003 Parameter RW, 4, register index width.
REQ-004 Port clk  in  1  single clock, all state on rising edge.
REQ-005 Port reset  in  1  asynchronous, active-high reset.
REQ-006 Port ex_valid / ex_ready  in / out  1 / 1  upstream handshake from execute (ALU) stage.
REQ-007 Port ex_dout  in  DW  ALU result.
REQ-008 Port ex_cout, ex_vout, ex_djtaken  in  1 each  ALU carry, overflow and decrement-jump-taken outputs.
REQ-009 Port ex_rdest  in  RW  destination register; ex_wen  in  1  register write enable.
REQ-010 Port ex_flag_we  in  1  instruction updates C/V/Z; ex_is_dj  in  1  instruction is a DJ-class jump.
REQ-011 Port ex_target  in  AW  jump target address.
REQ-012 Port wb_valid / wb_ready  out / in  1 / 1  downstream handshake to register-file writeback.
REQ-013 Port wb_data  out  DW; wb_rdest  out  RW; wb_wen  out  1  writeback payload.
REQ-014 Port cflag, vflag, zflag  out  1 each  architectural flags, fed back as ALU cin/vin.
REQ-015 Port redirect_valid  out  1; redirect_pc  out  AW  PC redirect for taken DJ jumps.
REQ-016 Port fwd_valid  out  1; fwd_rdest  out  RW; fwd_data  out  DW  forwarding of oldest pending register write.

Function
REQ-017 Storage: two entries, main (M) and skid (S), each holding {data, rdest, wen}; states EMPTY, ONE (M valid), FULL (M and S valid).
REQ-018 ex_ready is registered and equals NOT FULL; it never depends combinationally on wb_ready.
REQ-019 Accept occurs when ex_valid and ex_ready are high on a clock edge; transfer out occurs when wb_valid and wb_ready are high.
REQ-020 Transitions: EMPTY+accept->ONE; ONE+accept only->FULL; ONE+out only->EMPTY; ONE+accept+out->ONE (new entry into M); FULL+out->ONE (S moves to M); FULL with no out holds.
REQ-021 wb_valid = M valid; wb_data/wb_rdest/wb_wen driven from M; data held stable while wb_valid is high and wb_ready is low.
REQ-022 Order is strictly FIFO; no entry is dropped or duplicated.
REQ-023 Flags update at accept, not at writeback, when ex_flag_we=1: cflag<=ex_cout, vflag<=ex_vout, zflag<=(ex_dout==0); otherwise they hold.
REQ-024 A taken DJ jump is an accepted instruction with ex_is_dj=1 and ex_djtaken=1.
REQ-025 On a taken DJ jump, redirect_valid is high for exactly one cycle after the accept edge, with redirect_pc=ex_target registered.
REQ-026 Shadow drop: any instruction accepted while redirect_valid is high is discarded; it is not stored, does not update flags, and cannot itself redirect.
REQ-027 A taken DJ jump is still stored, and its decremented register writes back normally.
REQ-028 Forwarding output: fwd_valid = M valid AND M.wen, with fwd_rdest/fwd_data from M.
REQ-029 ex_wen=0 entries still occupy a slot and complete the handshake with wb_wen=0.
REQ-030 Simultaneous accept and out in FULL cannot occur, because ex_ready=0.
REQ-031 Simultaneous accept and out in ONE shall not change occupancy.

Reset
REQ-032 Asserting reset at any time, including mid-handshake, forces the following immediately: EMPTY, ex_ready=0, wb_valid=0, wb_wen=0, fwd_valid=0, redirect_valid=0, cflag=vflag=zflag=0, redirect_pc=0, wb_data=0, wb_rdest=0.
REQ-033 ex_ready rises on the first clock edge after reset deasserts; in-flight entries are lost.

Verification
REQ-034 Back-to-back accepts of dout=1,2,3 with wb_ready=1 -> wb_data 1,2,3 on consecutive cycles; ex_ready stays 1.
REQ-035 wb_ready=0 with three offered entries -> two accepted and ex_ready=0 after the second; after wb_ready=1, output order is 1,2 then 3.
REQ-036 Accept with flag_we=1, dout=0, cout=1, vout=0 -> next cycle cflag=1, vflag=0, zflag=1; a following flag_we=0 entry leaves the flags unchanged.
REQ-037 Accept of a DJ jump with djtaken=1, target=0x000100 -> redirect_valid=1 for one cycle with redirect_pc=0x000100; an entry accepted in that cycle never appears on wb and does not change the flags.
REQ-038 Reset asserted while FULL -> wb_valid=0 and cflag=0 immediately, without waiting for a clock edge; ex_ready=1 one edge after reset release.
